// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain
// Brief    : Read-side controller for a 16-bit synchronous FIFO. Issues reads,
//            captures returned words into a 3-entry skid buffer and presents
//            them as a valid/ready stream. Optional burst-last marking is
//            enabled by defining FIFO_DRAIN_LAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_drain #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drain_en,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              idle
);

    localparam logic [1:0] PTR_MAX = 2'd2;
    localparam logic [2:0] SLOTS   = 3'd3;

    logic [DATA_W-1:0] mem_q [3];
    logic [DATA_W-1:0] mem_d [3];
    logic [1:0]        head_q, head_d;
    logic [1:0]        tail_q, tail_d;
    logic [1:0]        occ_q,  occ_d;
    logic              pend_q, pend_d;
    logic              idle_q, idle_d;
    logic              push;
    logic              pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == PTR_MAX) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit covers buffered words plus the one in flight, so a read is only
    // issued when its data is guaranteed a slot; out_ready is never consulted.
    always_comb begin
        fifo_rd = !rst && drain_en && !empty &&
                  (({1'b0, occ_q} + {2'b0, pend_q}) < SLOTS);
    end

    always_comb begin
        push   = pend_q;
        pop    = (occ_q != 2'd0) && out_ready;
        pend_d = fifo_rd;
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push) begin
            mem_d[tail_q] = fifo_data;
            tail_d        = ptr_next(tail_q);
        end
        if (pop) begin
            head_d = ptr_next(head_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        idle_d = (occ_d == 2'd0) && !pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 2'd0;
            tail_q <= 2'd0;
            occ_q  <= 2'd0;
            pend_q <= 1'b0;
            idle_q <= 1'b1;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            pend_q <= pend_d;
            idle_q <= idle_d;
        end
    end

    always_comb begin
        out_valid = (occ_q != 2'd0);
        out_data  = mem_q[head_q];
        idle      = idle_q;
    end

`ifdef FIFO_DRAIN_LAST_EN
    localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

    logic [15:0] burst_cnt_q, burst_cnt_d;

    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (pop) begin
            burst_cnt_d = (burst_cnt_q == LAST_IDX) ? 16'd0 : burst_cnt_q + 16'd1;
        end
        out_last = out_valid && (burst_cnt_q == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt_q <= 16'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    always_comb begin
        out_last = 1'b0;
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (({1'b0, occ_q} + {2'b0, pend_q}) <= SLOTS);
        end
        assert (BURST_LEN >= 1 && BURST_LEN <= 65535);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_drain
// Brief    : Randomised bench for fifo_drain with a behavioural FIFO and a
//            queue-based reference of words read but not yet delivered.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_drain;

    localparam int DW     = 16;
    localparam int BL     = 4;
    localparam int FDEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          drain_en;
    logic          empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          idle;

    fifo_drain #(.DATA_W(DW), .BURST_LEN(BL)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .drain_en  (drain_en),
        .empty     (empty),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // fq: FIFO contents, wq: words waiting to be written, exp_q: words read
    // from the FIFO and owed downstream (oldest first), deliv_q: accepted words.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] wq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] deliv_q[$];
    int            last_pos[$];
    bit            pend_m;
    int            cnt_m;
    int            cycle;
    int            rd_count;
    int            first_rd_cyc, last_rd_cyc, first_val_cyc;
    int            wr_pct, rdy_pct, drain_pct;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic tick();
        bit exp_rd, exp_valid, exp_last, acc, rd_now;
        int buffered;
        @(negedge clk);
        buffered  = exp_q.size() - int'(pend_m);
        exp_valid = (buffered > 0);
        exp_rd    = !rst && drain_en && !empty && (exp_q.size() < 3);
`ifdef FIFO_DRAIN_LAST_EN
        exp_last  = exp_valid && (cnt_m == BL - 1);
`else
        exp_last  = 1'b0;
`endif
        check_eq("fifo_rd", fifo_rd, exp_rd);
        check_eq("rd_vs_empty", fifo_rd & empty, 0);
        check_eq("out_valid", out_valid, exp_valid);
        if (exp_valid) check_eq("out_data", out_data, exp_q[0]);
        check_eq("idle", idle, exp_q.size() == 0);
        check_eq("out_last", out_last, exp_last);
        acc    = exp_valid && out_ready;
        rd_now = fifo_rd;
        if (rd_now) begin
            rd_count++;
            if (first_rd_cyc < 0) first_rd_cyc = cycle;
            last_rd_cyc = cycle;
        end
        if (exp_valid && first_val_cyc < 0) first_val_cyc = cycle;
        if (acc && out_last) last_pos.push_back(deliv_q.size());
        @(posedge clk);
        #1;
        cycle++;
        if (rst) begin
            exp_q.delete();
            pend_m = 1'b0;
            cnt_m  = 0;
        end else begin
            if (acc) begin
                deliv_q.push_back(exp_q.pop_front());
                cnt_m = (cnt_m == BL - 1) ? 0 : cnt_m + 1;
            end
            pend_m = rd_now;
        end
        if (rd_now && fq.size() > 0) begin
            fifo_data = fq.pop_front();
            if (!rst) exp_q.push_back(fifo_data);
        end
        if (wq.size() > 0 && fq.size() < FDEPTH && $urandom_range(99) < wr_pct)
            fq.push_back(wq.pop_front());
        empty     = (fq.size() == 0);
        out_ready = ($urandom_range(99) < rdy_pct);
        drain_en  = ($urandom_range(99) < drain_pct);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic preload(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
        empty = (fq.size() == 0);
    endtask

    task automatic start_test(input int rdy);
        deliv_q.delete();
        last_pos.delete();
        rd_count      = 0;
        first_rd_cyc  = -1;
        last_rd_cyc   = -1;
        first_val_cyc = -1;
        rdy_pct       = rdy;
        out_ready     = (rdy >= 100);
        drain_pct     = 100;
        drain_en      = 1'b1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        logic [DW-1:0] next_word;
        rst = 1'b1; drain_en = 1'b0; empty = 1'b1; fifo_data = '0; out_ready = 1'b0;
        pend_m = 1'b0; cnt_m = 0; cycle = 0;
        wr_pct = 0; rdy_pct = 0; drain_pct = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_fifo_rd", fifo_rd, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_idle", idle, 1);
        rst = 1'b0;

        // Straight drain of four words
        start_test(100);
        preload(16'h0001, 4);
        run(10);
        check_eq("t1_rd_count", rd_count, 4);
        check_eq("t1_rd_consecutive", last_rd_cyc - first_rd_cyc, 3);
        check_eq("t1_latency", first_val_cyc - first_rd_cyc, 2);
        check_eq("t1_deliv_count", deliv_q.size(), 4);
        for (int i = 0; i < 4 && i < deliv_q.size(); i++)
            check_eq("t1_order", deliv_q[i], 32'(i + 1));
        check_eq("t1_idle", idle, 1);

        // Backpressure
        start_test(0);
        preload(16'h0001, 10);
        run(10);
        check_eq("t2_rd_stall", rd_count, 3);
        check_eq("t2_hold_data", out_data, 16'h0001);
        check_eq("t2_hold_valid", out_valid, 1);
        rdy_pct = 100; out_ready = 1'b1;
        run(20);
        check_eq("t2_deliv_count", deliv_q.size(), 10);
        for (int i = 0; i < 10 && i < deliv_q.size(); i++)
            check_eq("t2_order", deliv_q[i], 32'(i + 1));

        // Empty boundary
        start_test(100);
        preload(16'hABCD, 1);
        run(8);
        check_eq("t3_single_rd", rd_count, 1);
        check_eq("t3_deliv_count", deliv_q.size(), 1);
        if (deliv_q.size() > 0) check_eq("t3_word0", deliv_q[0], 16'hABCD);
        wq.push_back(16'h1234);
        wr_pct = 100;
        run(8);
        check_eq("t3_second_rd", rd_count, 2);
        check_eq("t3_deliv_count2", deliv_q.size(), 2);
        if (deliv_q.size() > 1) check_eq("t3_word1", deliv_q[1], 16'h1234);

        // Random backpressure and drain_en over 1024 words with a filling FIFO
        start_test(50);
        drain_pct = 90;
        wr_pct    = 70;
        for (int i = 0; i < 1024; i++) wq.push_back(DW'(i));
        guard = 0;
        while (deliv_q.size() < 1024 && guard < 20000) begin
            tick();
            guard++;
        end
        check_eq("t4_deliv_count", deliv_q.size(), 1024);
        for (int i = 0; i < deliv_q.size(); i++)
            check_eq("t4_order", deliv_q[i], 32'(i));
        wr_pct = 0;

        // Reset while one word is in flight and two are buffered
        start_test(0);
        preload(16'h5000, 8);
        guard = 0;
        while (!(exp_q.size() == 3 && pend_m) && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("t5_reach_state", exp_q.size() == 3 && pend_m, 1);
        next_word = fq[0];
        pulse_reset();
        check_eq("t5_valid_after_rst", out_valid, 0);
        check_eq("t5_idle_after_rst", idle, 1);
        rdy_pct = 100; out_ready = 1'b1;
        run(15);
        check_eq("t5_resume_count", deliv_q.size(), 5);
        if (deliv_q.size() > 0) check_eq("t5_resume_word", deliv_q[0], next_word);

        // Burst-last marking
        pulse_reset();
        start_test(100);
        preload(16'h0100, 8);
        run(15);
        check_eq("t6_deliv_count", deliv_q.size(), 8);
`ifdef FIFO_DRAIN_LAST_EN
        check_eq("t6_last_count", last_pos.size(), 2);
        if (last_pos.size() > 0) check_eq("t6_last_pos0", last_pos[0], 3);
        if (last_pos.size() > 1) check_eq("t6_last_pos1", last_pos[1], 7);
`else
        check_eq("t6_last_count", last_pos.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
